// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the RAM port arbiter: FSM state encoding,
//   RAM read latency and the legal range of the fetch starvation limit.
package ram_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_D_WR  = 3'd1,
      ST_D_RD  = 3'd2,
      ST_D_RSP = 3'd3,
      ST_I_RD  = 3'd4,
      ST_I_RSP = 3'd5
   } arb_state_t;

   // RAM returns read data exactly one cycle after the read strobe.
   localparam int unsigned RAM_LATENCY = 1;

   localparam int unsigned STARVE_MIN = 1;
   localparam int unsigned STARVE_MAX = 15;
   localparam int unsigned STARVE_W   = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
//   Counts data transactions granted while fetch is waiting. Saturates at
//   its maximum value; clear has priority over increment.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   inc       count one data transaction granted over a waiting fetch
//   clr       fetch was granted, start over
//   hit       count has reached LIMIT
module arb_starve_cnt
   import ram_arb_pkg::*;
#(
   parameter int unsigned LIMIT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);
   localparam logic [STARVE_W-1:0] CNT_MAX = '1;

   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (cnt == LIMIT_V);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one RAM port between instruction fetch and memory-stage data
//   accesses. Data has priority over fetch; a write+read request is served
//   as a write followed by a read. One transaction in flight at a time.
// Ports:
//   clk, rst                   clock and asynchronous active-low reset
//   if_req/if_addr             fetch request (level, held until if_valid)
//   if_word/if_valid           fetch response
//   d_read/d_write             data requests (levels, held until d_done)
//   d_r_addr/d_w_addr/d_w_line data addresses and write data
//   d_r_line/d_done            data response
//   stall                      some requester is still waiting
//   ram_*                      RAM bus, 1-cycle read latency
// Configuration:
//   ARB_STARVE_GUARD_EN  when defined, fetch is forced after STARVE_LIMIT
//                        consecutive data transactions granted over it.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | port free, arbitrate on next edge
// D_WR     | data write strobe on RAM
// D_RD     | data read strobe on RAM
// D_RSP    | read data returned to memory stage, d_done
// I_RD     | fetch read strobe on RAM
// I_RSP    | fetched word returned, if_valid
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_word,
   output logic        if_valid,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_r_addr,
   input  logic [31:0] d_w_addr,
   input  logic [31:0] d_w_line,
   output logic [31:0] d_r_line,
   output logic        d_done,
   output logic        stall,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_w_line,
   output logic        ram_read,
   output logic        ram_write,
   input  logic [31:0] ram_r_line
);

   if (STARVE_LIMIT < STARVE_MIN || STARVE_LIMIT > STARVE_MAX) begin : g_bad_limit
      $error("STARVE_LIMIT out of range");
   end
   if (RAM_LATENCY != 1) begin : g_bad_latency
      $error("arbiter FSM assumes a 1-cycle RAM read latency");
   end

   arb_state_t state, state_nxt;

   logic [31:0] r_addr_q, w_addr_q, w_line_q, i_addr_q;
   logic        rd_pend_q;
   logic        force_fetch;
   logic        leave_idle;

`ifdef ARB_STARVE_GUARD_EN
   logic starve_hit;
   logic starve_inc;
   logic starve_clr;

   assign starve_inc = (state == ST_IDLE) && if_req &&
                       (state_nxt == ST_D_WR || state_nxt == ST_D_RD);
   assign starve_clr = (state == ST_IDLE) && (state_nxt == ST_I_RD);

   arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .inc (starve_inc),
      .clr (starve_clr),
      .hit (starve_hit)
   );

   assign force_fetch = starve_hit & if_req;
`else
   assign force_fetch = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // All requester fields are captured together whenever a transaction
   // starts; only IDLE looks at the live inputs.
   assign leave_idle = (state == ST_IDLE) && (state_nxt != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr_q  <= '0;
         w_addr_q  <= '0;
         w_line_q  <= '0;
         i_addr_q  <= '0;
         rd_pend_q <= 1'b0;
      end else if (leave_idle) begin
         r_addr_q  <= d_r_addr;
         w_addr_q  <= d_w_addr;
         w_line_q  <= d_w_line;
         i_addr_q  <= if_addr;
         rd_pend_q <= d_read & d_write;
      end
   end

   always_comb begin
      state_nxt  = state;
      if_word    = '0;
      if_valid   = 1'b0;
      d_r_line   = '0;
      d_done     = 1'b0;
      ram_addr   = '0;
      ram_w_line = '0;
      ram_read   = 1'b0;
      ram_write  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (force_fetch)  state_nxt = ST_I_RD;
            else if (d_write) state_nxt = ST_D_WR;
            else if (d_read)  state_nxt = ST_D_RD;
            else if (if_req)  state_nxt = ST_I_RD;
         end
         ST_D_WR: begin
            ram_write  = 1'b1;
            ram_addr   = w_addr_q;
            ram_w_line = w_line_q;
            d_done     = ~rd_pend_q;
            state_nxt  = rd_pend_q ? ST_D_RD : ST_IDLE;
         end
         ST_D_RD: begin
            ram_read  = 1'b1;
            ram_addr  = r_addr_q;
            state_nxt = ST_D_RSP;
         end
         ST_D_RSP: begin
            d_done    = 1'b1;
            d_r_line  = ram_r_line;
            state_nxt = ST_IDLE;
         end
         ST_I_RD: begin
            ram_read  = 1'b1;
            ram_addr  = i_addr_q;
            state_nxt = ST_I_RSP;
         end
         ST_I_RSP: begin
            if_valid  = 1'b1;
            if_word   = ram_r_line;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stall = (if_req & ~if_valid) | ((d_read | d_write) & ~d_done);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter with a small 1-cycle-latency RAM
//   model. Inputs are driven and outputs checked on the falling edge.
//   Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_word;
   logic        if_valid;
   logic        d_read, d_write;
   logic [31:0] d_r_addr, d_w_addr, d_w_line;
   logic [31:0] d_r_line;
   logic        d_done;
   logic        stall;
   logic [31:0] ram_addr, ram_w_line;
   logic        ram_read, ram_write;
   logic [31:0] ram_r_line;

   logic [31:0] mem [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_word    (if_word),
      .if_valid   (if_valid),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_r_addr   (d_r_addr),
      .d_w_addr   (d_w_addr),
      .d_w_line   (d_w_line),
      .d_r_line   (d_r_line),
      .d_done     (d_done),
      .stall      (stall),
      .ram_addr   (ram_addr),
      .ram_w_line (ram_w_line),
      .ram_read   (ram_read),
      .ram_write  (ram_write),
      .ram_r_line (ram_r_line)
   );

   always @(posedge clk) begin
      if (ram_read)  ram_r_line <= mem[ram_addr[9:2]];
      if (ram_write) mem[ram_addr[9:2]] <= ram_w_line;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [31:0] rd_addrs [0:7];
   int          n_rd;
   logic        fetch_seen;
   logic        exp_guard;
   logic [31:0] exp_fourth;
   int          budget;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[64]    = 32'hDEADBEEF;
      ram_r_line = 32'h0;
      rst      = 1'b0;
      if_req   = 1'b0;
      if_addr  = 32'h0;
      d_read   = 1'b0;
      d_write  = 1'b0;
      d_r_addr = 32'h0;
      d_w_addr = 32'h0;
      d_w_line = 32'h0;
`ifdef ARB_STARVE_GUARD_EN
      exp_guard = 1'b1;
`else
      exp_guard = 1'b0;
`endif

      // reset state
      step();
      check_val("rst_ram_read",  {31'd0, ram_read},  32'd0);
      check_val("rst_ram_write", {31'd0, ram_write}, 32'd0);
      check_val("rst_ram_addr",  ram_addr,           32'd0);
      check_val("rst_done",      {31'd0, d_done},    32'd0);
      check_val("rst_valid",     {31'd0, if_valid},  32'd0);
      check_val("rst_stall",     {31'd0, stall},     32'd0);
      if_req = 1'b1;
      #1;
      check_val("rst_stall_follow", {31'd0, stall}, 32'd1);
      if_req = 1'b0;
      step();
      rst = 1'b1;
      step();

      // fetch only
      if_req = 1'b1; if_addr = 32'h100;
      #1 check_val("f_stall_pre", {31'd0, stall}, 32'd1);
      step();
      check_val("f_ram_read", {31'd0, ram_read}, 32'd1);
      check_val("f_ram_addr", ram_addr, 32'h100);
      check_val("f_valid_early", {31'd0, if_valid}, 32'd0);
      check_val("f_stall_wait", {31'd0, stall}, 32'd1);
      step();
      check_val("f_valid", {31'd0, if_valid}, 32'd1);
      check_val("f_word", if_word, 32'hDEADBEEF);
      check_val("f_stall_rsp", {31'd0, stall}, 32'd0);
      check_val("f_rsp_no_read", {31'd0, ram_read}, 32'd0);
      if_req = 1'b0;
      step();
      check_val("f_valid_drop", {31'd0, if_valid}, 32'd0);
      check_val("f_word_zero", if_word, 32'd0);

      // data write
      d_write = 1'b1; d_w_addr = 32'h40; d_w_line = 32'h12345678;
      step();
      check_val("w_ram_write", {31'd0, ram_write}, 32'd1);
      check_val("w_ram_read",  {31'd0, ram_read},  32'd0);
      check_val("w_ram_addr",  ram_addr,           32'h40);
      check_val("w_ram_line",  ram_w_line,         32'h12345678);
      check_val("w_done",      {31'd0, d_done},    32'd1);
      d_write = 1'b0;
      step();
      check_val("w_done_drop", {31'd0, d_done}, 32'd0);
      check_val("w_mem", mem[16], 32'h12345678);

      // write then read, same address
      d_write = 1'b1; d_read = 1'b1;
      d_w_addr = 32'h40; d_r_addr = 32'h40; d_w_line = 32'hA5A5A5A5;
      step();
      check_val("wr_c1_write", {31'd0, ram_write}, 32'd1);
      check_val("wr_c1_done",  {31'd0, d_done},    32'd0);
      step();
      check_val("wr_c2_read",  {31'd0, ram_read},  32'd1);
      check_val("wr_c2_write", {31'd0, ram_write}, 32'd0);
      check_val("wr_c2_addr",  ram_addr,           32'h40);
      check_val("wr_c2_done",  {31'd0, d_done},    32'd0);
      step();
      check_val("wr_c3_done",  {31'd0, d_done},    32'd1);
      check_val("wr_c3_line",  d_r_line,           32'hA5A5A5A5);
      check_val("wr_c3_noop",  {30'd0, ram_read, ram_write}, 32'd0);
      d_write = 1'b0; d_read = 1'b0;
      step();

      // simultaneous fetch and data read: data first
      if_req = 1'b1; if_addr = 32'h100;
      d_read = 1'b1; d_r_addr = 32'h40;
      step();
      check_val("sim_d_addr", ram_addr, 32'h40);
      step();
      check_val("sim_d_done", {31'd0, d_done}, 32'd1);
      check_val("sim_d_line", d_r_line, 32'hA5A5A5A5);
      check_val("sim_f_wait", {31'd0, if_valid}, 32'd0);
      d_read = 1'b0;
      step();
      check_val("sim_idle_stall", {31'd0, stall}, 32'd1);
      check_val("sim_idle_noop", {30'd0, ram_read, ram_write}, 32'd0);
      step();
      check_val("sim_f_addr", ram_addr, 32'h100);
      step();
      check_val("sim_f_valid", {31'd0, if_valid}, 32'd1);
      check_val("sim_f_word",  if_word, 32'hDEADBEEF);
      if_req = 1'b0;
      step();

      // starvation: d_read held through back-to-back transactions
      n_rd = 0; fetch_seen = 1'b0;
      if_req = 1'b1; if_addr = 32'h100;
      d_read = 1'b1; d_r_addr = 32'h40;
      for (int c = 0; c < 16; c++) begin
         step();
         if (ram_read && n_rd < 8) begin
            rd_addrs[n_rd] = ram_addr;
            n_rd++;
         end
         if (if_valid) begin
            fetch_seen = 1'b1;
            if_req = 1'b0;
         end
      end
      exp_fourth = exp_guard ? 32'h100 : 32'h40;
      check_val("starve_n_rd_ge4", {31'd0, (n_rd >= 4)}, 32'd1);
      check_val("starve_1st", rd_addrs[0], 32'h40);
      check_val("starve_3rd", rd_addrs[2], 32'h40);
      check_val("starve_4th", rd_addrs[3], exp_fourth);
      check_val("starve_fetch_seen", {31'd0, fetch_seen}, {31'd0, exp_guard});
      d_read = 1'b0;
      budget = 0;
      while (if_req && budget < 10) begin
         step();
         if (if_valid) if_req = 1'b0;
         budget++;
      end
      check_val("starve_fetch_drain", {31'd0, if_req}, 32'd0);
      step();
      step();

      // reset during D_WR
      d_write = 1'b1; d_w_addr = 32'h80; d_w_line = 32'h11111111;
      step();
      check_val("rw_write_pre", {31'd0, ram_write}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_val("rw_write_drop", {31'd0, ram_write}, 32'd0);
      check_val("rw_no_done",    {31'd0, d_done},    32'd0);
      check_val("rw_addr_zero",  ram_addr,           32'd0);
      d_write = 1'b0; d_read = 1'b1; d_r_addr = 32'h40;
      step();
      check_val("rw_hold_noop", {30'd0, ram_read, ram_write}, 32'd0);
      check_val("rw_stall_follow", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      step();
      check_val("rw_fresh_read", {31'd0, ram_read}, 32'd1);
      check_val("rw_fresh_addr", ram_addr, 32'h40);
      step();
      check_val("rw_fresh_done", {31'd0, d_done}, 32'd1);
      check_val("rw_fresh_line", d_r_line, 32'hA5A5A5A5);
      d_read = 1'b0;
      step();
      check_val("rw_end_stall", {31'd0, stall}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
